// File: rtl/reg_seq_ctrl_if.sv
// Bus between the instruction source/ALU and reg_seq_ctrl, including the
// register-file control lines the sequencer drives.
interface reg_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      INSTR;
    logic             INSTR_VALID;
    logic             INSTR_READY;
    logic [7:0]       ALU_RESULT;
    logic [1:0]       DIR_A;
    logic [1:0]       DIR_B;
    logic [1:0]       DIR_WR;
    logic             EN;
    logic [7:0]       DI;
    logic [3:0]       ALU_OP;
    logic             RETIRE;
    logic             HALTED;
    logic [CNT_W-1:0] INSTR_CNT;
    logic [2:0]       dbg_state;

    modport master (
        output INSTR, INSTR_VALID, ALU_RESULT,
        input  INSTR_READY, DIR_A, DIR_B, DIR_WR, EN, DI, ALU_OP,
               RETIRE, HALTED, INSTR_CNT, dbg_state
    );

    modport slave (
        input  INSTR, INSTR_VALID, ALU_RESULT,
        output INSTR_READY, DIR_A, DIR_B, DIR_WR, EN, DI, ALU_OP,
               RETIRE, HALTED, INSTR_CNT, dbg_state
    );
endinterface

// File: rtl/reg_seq_ctrl.sv
// Multi-cycle sequencer for the 4x8 register file: fetch one instruction,
// read operands, execute on the external ALU, write back, count retirements.
module reg_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          RST,
    reg_seq_ctrl_if.slave bus
);
    // Handshake: an instruction transfers on a rising edge where INSTR_VALID
    // and INSTR_READY are both 1; INSTR_READY is 1 only in IDLE, and the
    // source must hold INSTR stable until the transfer.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_EXEC     = 3'd2,
        S_WRITE    = 3'd3,
        S_HALT_RET = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      ir;
    logic [7:0]       res;
    logic [CNT_W-1:0] cnt;

    logic [3:0] ir_op;
    logic [1:0] ir_rd;
    logic [1:0] ir_ra;
    logic [1:0] ir_rb;
    logic [7:0] ir_imm;
    logic [3:0] in_op;

    assign ir_op  = ir[15:12];
    assign ir_rd  = ir[11:10];
    assign ir_ra  = ir[9:8];
    assign ir_imm = ir[7:0];
    assign ir_rb  = ir[1:0];
    assign in_op  = bus.INSTR[15:12];

    logic       ready;
    logic       en;
    logic [1:0] dir_a;
    logic [1:0] dir_b;
    logic [1:0] dir_wr;
    logic [7:0] di;
    logic [3:0] alu_op;
    logic       retire;
    logic       halted;

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= S_IDLE;
            ir    <= '0;
            res   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.INSTR_VALID) begin
                ir <= bus.INSTR;
            end
            if (state == S_EXEC) begin
                res <= bus.ALU_RESULT;
            end
            if (retire) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Outputs depend only on state, ir and res; INSTR only steers next state.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        en        = 1'b0;
        dir_a     = 2'd0;
        dir_b     = 2'd0;
        dir_wr    = 2'd0;
        di        = 8'd0;
        alu_op    = 4'd0;
        retire    = 1'b0;
        halted    = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.INSTR_VALID) begin
                    if (in_op == OP_LDI) begin
                        state_nxt = S_WRITE;
                    end else if (in_op == OP_HALT) begin
                        state_nxt = S_HALT_RET;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                dir_a     = ir_ra;
                dir_b     = ir_rb;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                dir_a  = ir_ra;
                dir_b  = ir_rb;
                alu_op = ir_op;
                if (ir_op == OP_NOP) begin
                    retire    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                en        = 1'b1;
                dir_wr    = ir_rd;
                di        = (ir_op == OP_LDI) ? ir_imm : res;
                retire    = 1'b1;
                state_nxt = S_IDLE;
            end
            // Split halt so RETIRE pulses only on the first halted cycle.
            S_HALT_RET: begin
                retire    = 1'b1;
                halted    = 1'b1;
                state_nxt = S_HALT;
            end
            S_HALT: begin
                halted    = 1'b1;
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.INSTR_READY = ready;
    assign bus.EN          = en;
    assign bus.DIR_A       = dir_a;
    assign bus.DIR_B       = dir_b;
    assign bus.DIR_WR      = dir_wr;
    assign bus.DI          = di;
    assign bus.ALU_OP      = alu_op;
    assign bus.RETIRE      = retire;
    assign bus.HALTED      = halted;
    assign bus.INSTR_CNT   = cnt;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed bench for reg_seq_ctrl with a register-file/ALU model and a
// scoreboard that checks every retirement against an expected queue.
module tb_reg_seq_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    reg_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    reg_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    // Register file with operand latches, plus a small combinational ALU.
    logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] doa = 8'h00;
    logic [7:0] dob = 8'h00;
    logic [7:0] alu_res;

    always @(posedge clk) begin
        if (bus.EN) rf[bus.DIR_WR] <= bus.DI;
        doa <= rf[bus.DIR_A];
        dob <= rf[bus.DIR_B];
    end

    always_comb begin
        alu_res = 8'h00;
        case (bus.ALU_OP)
            4'h2:    alu_res = doa + dob;
            4'h3:    alu_res = doa - dob;
            4'h4:    alu_res = doa & dob;
            default: alu_res = doa ^ dob;
        endcase
    end
    assign bus.ALU_RESULT = alu_res;

    // Scoreboard entry: {EN, DIR_WR, DI} seen in the RETIRE cycle.
    logic [10:0] exp_q [$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        logic [10:0] exp;
        if (!RST && bus.RETIRE) begin
            if (exp_q.size() == 0) begin
                fail_evt("unexpected_retire");
            end else begin
                exp = exp_q.pop_front();
                chk("retire_write", {21'd0, bus.EN, bus.DIR_WR, bus.DI}, {21'd0, exp});
            end
        end
        if (!RST && bus.EN && !bus.RETIRE) fail_evt("en_without_retire");
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.INSTR_READY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_evt("ready_timeout");
    endtask

    // Returns 1 time unit after the handshake edge.
    task automatic send(input logic [15:0] ins, input logic [10:0] exp, input bit push);
        @(negedge clk);
        bus.INSTR       = ins;
        bus.INSTR_VALID = 1'b1;
        wait_ready();
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.INSTR_VALID = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.INSTR       = 16'h0000;
        bus.INSTR_VALID = 1'b0;
        RST             = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;

        chk("rst_ready", bus.INSTR_READY, 1);
        chk("rst_en", bus.EN, 0);
        chk("rst_retire", bus.RETIRE, 0);
        chk("rst_halted", bus.HALTED, 0);
        chk("rst_cnt", bus.INSTR_CNT, 0);
        chk("rst_busses", {bus.DIR_A, bus.DIR_B, bus.DIR_WR, bus.DI, bus.ALU_OP}, 0);

        // LDI r1,0x5A ; LDI r2,0x23
        send(16'h145A, {1'b1, 2'd1, 8'h5A}, 1'b1);
        chk("ldi1_en", bus.EN, 1);
        chk("ldi1_wr", {bus.DIR_WR, bus.DI}, {2'd1, 8'h5A});
        send(16'h1823, {1'b1, 2'd2, 8'h23}, 1'b1);
        chk("ldi2_wr", {bus.EN, bus.DIR_WR, bus.DI}, {1'b1, 2'd2, 8'h23});
        step();
        chk("ldi_cnt", bus.INSTR_CNT, 2);

        // ADD r3 = r1 + r2
        send(16'h2D02, {1'b1, 2'd3, 8'h7D}, 1'b1);
        chk("add_read_dir", {bus.DIR_A, bus.DIR_B}, {2'd1, 2'd2});
        chk("add_read_op", {bus.EN, bus.ALU_OP, bus.INSTR_READY}, 0);
        step();
        chk("add_exec_op", bus.ALU_OP, 4'h2);
        chk("add_exec_dir", {bus.DIR_A, bus.DIR_B, bus.EN}, {2'd1, 2'd2, 1'b0});
        step();
        chk("add_write", {bus.EN, bus.DIR_WR, bus.DI, bus.RETIRE}, {1'b1, 2'd3, 8'h7D, 1'b1});
        chk("add_write_idle_bus", {bus.ALU_OP, bus.DIR_A, bus.DIR_B}, 0);
        step();
        chk("add_idle", {bus.INSTR_READY, bus.RETIRE, bus.EN}, {1'b1, 1'b0, 1'b0});
        chk("add_cnt", bus.INSTR_CNT, 3);

        // SUB r0 = r3 - r1 (reads r3 right after its writeback); ADD r1 = r1 + r1
        send(16'h3301, {1'b1, 2'd0, 8'h23}, 1'b1);
        send(16'h2501, {1'b1, 2'd1, 8'hB4}, 1'b1);
        repeat (3) step();
        chk("alu_cnt", bus.INSTR_CNT, 5);

        // NOP with INSTR_VALID held high throughout
        @(negedge clk);
        bus.INSTR       = 16'h0000;
        bus.INSTR_VALID = 1'b1;
        wait_ready();
        exp_q.push_back(11'd0);
        step();
        chk("nop_read", {bus.INSTR_READY, bus.RETIRE, bus.EN}, 0);
        step();
        chk("nop_exec", {bus.INSTR_READY, bus.RETIRE, bus.EN}, {1'b0, 1'b1, 1'b0});
        step();
        chk("nop_idle_again", bus.INSTR_READY, 1);
        exp_q.push_back(11'd0);
        step();
        chk("nop_second_taken", bus.INSTR_READY, 0);
        bus.INSTR_VALID = 1'b0;
        step();
        step();
        chk("nop_done", {bus.INSTR_READY, bus.EN}, {1'b1, 1'b0});
        chk("nop_cnt", bus.INSTR_CNT, 7);

        // HALT, then a valid LDI that must never be taken
        send(16'hF000, 11'd0, 1'b1);
        chk("halt_first", {bus.HALTED, bus.RETIRE, bus.INSTR_READY}, {1'b1, 1'b1, 1'b0});
        bus.INSTR       = 16'h1477;
        bus.INSTR_VALID = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("halt_hold", {bus.HALTED, bus.INSTR_READY, bus.RETIRE, bus.EN}, {1'b1, 1'b0, 1'b0, 1'b0});
        end
        chk("halt_cnt", bus.INSTR_CNT, 8);
        RST             = 1'b1;
        bus.INSTR_VALID = 1'b0;
        step();
        RST = 1'b0;
        chk("halt_rst", {bus.HALTED, bus.INSTR_READY}, {1'b0, 1'b1});
        chk("halt_rst_cnt", bus.INSTR_CNT, 0);

        // Reset during EXEC of an ADD aborts it
        send(16'h2D02, 11'd0, 1'b0);
        step();
        chk("abort_in_exec", bus.ALU_OP, 4'h2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort_after", {bus.EN, bus.RETIRE, bus.INSTR_READY}, {1'b0, 1'b0, 1'b1});
        chk("abort_cnt", bus.INSTR_CNT, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_quiet", {bus.EN, bus.INSTR_READY}, {1'b0, 1'b1});
        end

        // 17 LDIs wrap the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            logic [1:0] rd;
            logic [7:0] imm;
            rd  = 2'(i);
            imm = 8'(8'h30 + i);
            send({4'h1, rd, 2'b00, imm}, {1'b1, rd, imm}, 1'b1);
            step();
            if (i == 14) chk("wrap_cnt15", bus.INSTR_CNT, 15);
            if (i == 15) chk("wrap_cnt0", bus.INSTR_CNT, 0);
        end
        chk("wrap_cnt_end", bus.INSTR_CNT, 1);

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
